// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and default
// PC parameters used by fetch_unit and its PC register.
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } fetch_state_t;

  localparam int unsigned DEF_RESET_PC = 0;
  localparam int unsigned DEF_PC_STEP  = 1;
  localparam int unsigned DEF_TIMEOUT  = 15;

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Program-counter register: synchronous reset to RESET_PC, loads d when
// load is asserted, otherwise holds.
module pc_register
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= ADDR_W'(RESET_PC);
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC / instruction-fetch stage: one imem read per instruction, holds the
// instruction until retire, with halt and fetch-timeout terminal states.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned RESET_PC = DEF_RESET_PC,
  parameter int unsigned PC_STEP  = DEF_PC_STEP,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_seq,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic              retire,
  input  logic              halt,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       retired_cnt
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_t     state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             pc_load;
  logic             wait_expired;

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (next_pc),
    .q    (pc)
  );

  assign imem_addr    = pc;
  assign pc_seq       = pc + ADDR_W'(PC_STEP);
  // Gated by rst so no request escapes while reset is held.
  assign imem_req     = (state == S_FETCH) && !rst;
  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // NOTE: every signal written here gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    case (state)
      S_FETCH: state_next = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)       state_next = S_ISSUE;
        else if (wait_expired) state_next = S_FAULT;
      end
      S_ISSUE: begin
        if (retire) begin
          if (halt) begin
            state_next = S_HALT;
          end else begin
            state_next = S_FETCH;
            pc_load    = 1'b1;
          end
        end
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_FETCH: wait_cnt <= '0;
        S_WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
          end else begin
            // Counter reaches TIMEOUT on the cycle the fault is raised.
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_expired) fault <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (retire) begin
            instr_valid <= 1'b0;
            retired_cnt <= retired_cnt + 32'd1;
            if (halt) halted <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner cases,
// and randomized transactions against a transaction-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_seq;
  logic [31:0] next_pc;
  logic        retire;
  logic        halt;
  logic        halted;
  logic        fault;
  logic [31:0] retired_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural PC, retire count, last fetched word.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_instr;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_seq      (pc_seq),
    .next_pc     (next_pc),
    .retire      (retire),
    .halt        (halt),
    .halted      (halted),
    .fault       (fault),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rvalid;
    logic [31:0] rdata;
    logic        retire;
    logic [31:0] next_pc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_cnt;
  } vec_t;

  function automatic vec_t mk(logic rv, logic [31:0] rd, logic rt, logic [31:0] np,
                              logic rq, logic [31:0] ad, logic vl, logic [31:0] ins,
                              logic [31:0] cn);
    vec_t v;
    v.rvalid = rv;  v.rdata = rd;  v.retire = rt;  v.next_pc = np;
    v.exp_req = rq; v.exp_addr = ad; v.exp_valid = vl; v.exp_instr = ins;
    v.exp_cnt = cn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    retire = 1'b0; halt = 1'b0; next_pc = '0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_cnt", retired_cnt, 32'd0);
    rst = 1'b0;
    #1;
    m_pc = 32'd0; m_cnt = 32'd0; m_instr = 32'd0;
    check("rst_first_req", {31'b0, imem_req}, 32'd1);
  endtask

  // Entered at a negedge inside the FETCH cycle; leaves at a negedge in ISSUE.
  task automatic do_fetch(input int lat, input logic [31:0] data);
    check("fetch_req", {31'b0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, m_pc);
    @(negedge clk);
    for (int i = 1; i < lat; i++) begin
      check("wait_no_req", {31'b0, imem_req}, 32'd0);
      @(negedge clk);
    end
    imem_rvalid = 1'b1; imem_rdata = data;
    @(negedge clk);
    imem_rvalid = 1'b0; imem_rdata = $urandom;
    m_instr = data;
    check("issue_valid", {31'b0, instr_valid}, 32'd1);
    check("issue_instr", instr, m_instr);
    check("issue_pc", pc, m_pc);
    check("issue_pc_seq", pc_seq, m_pc + 32'd1);
  endtask

  // Entered at a negedge in ISSUE; leaves at the negedge of the next state.
  task automatic do_retire(input logic [31:0] npc, input logic h);
    retire = 1'b1; halt = h; next_pc = npc;
    @(negedge clk);
    retire = 1'b0; halt = 1'b0; next_pc = $urandom;
    m_cnt = m_cnt + 32'd1;
    if (!h) m_pc = npc;
    check("ret_valid", {31'b0, instr_valid}, 32'd0);
    check("ret_cnt", retired_cnt, m_cnt);
    check("ret_pc", pc, m_pc);
    check("ret_halted", {31'b0, halted}, {31'b0, h});
    check("ret_req", {31'b0, imem_req}, {31'b0, !h});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    logic [31:0] a0, a1, a2, held, npc;
    logic        ok;

    a0 = 32'h1000_0000; a1 = 32'h1000_0001; a2 = 32'h1000_0002;
    vecs[0] = mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
    vecs[1] = mk(1'b1, a0,    1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    vecs[2] = mk(1'b0, 32'd0, 1'b1, 32'd1, 1'b0, 32'd0, 1'b1, a0,    32'd0);
    vecs[3] = mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'd1, 1'b0, 32'd0, 32'd1);
    vecs[4] = mk(1'b1, a1,    1'b0, 32'd0, 1'b0, 32'd1, 1'b0, 32'd0, 32'd1);
    vecs[5] = mk(1'b0, 32'd0, 1'b1, 32'd2, 1'b0, 32'd1, 1'b1, a1,    32'd1);
    vecs[6] = mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'd2, 1'b0, 32'd0, 32'd2);
    vecs[7] = mk(1'b1, a2,    1'b0, 32'd0, 1'b0, 32'd2, 1'b0, 32'd0, 32'd2);
    vecs[8] = mk(1'b0, 32'd0, 1'b1, 32'd3, 1'b0, 32'd2, 1'b1, a2,    32'd2);
    vecs[9] = mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'd3, 1'b0, 32'd0, 32'd3);

    // Sequential stream, 1-cycle memory, immediate retire.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d_cnt", i), retired_cnt, vecs[i].exp_cnt);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
      imem_rvalid = vecs[i].rvalid; imem_rdata = vecs[i].rdata;
      retire = vecs[i].retire; next_pc = vecs[i].next_pc;
      @(negedge clk);
    end
    imem_rvalid = 1'b0; retire = 1'b0;

    // Taken branch from pc=5 to 0x40.
    do_reset();
    do_fetch(1, 32'hA);
    do_retire(32'd5, 1'b0);
    do_fetch(1, 32'hB);
    check("br_pc5", pc, 32'd5);
    do_retire(32'h40, 1'b0);
    check("br_addr", imem_addr, 32'h40);
    do_fetch(1, 32'hC);
    check("br_pc_seq", pc_seq, 32'h41);

    // Spurious rvalid in ISSUE, halt without retire, then retire in WAIT.
    held = instr;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; halt = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b0; halt = 1'b0;
    check("spur_instr", instr, held);
    check("spur_valid", {31'b0, instr_valid}, 32'd1);
    check("spur_halted", {31'b0, halted}, 32'd0);
    do_retire(32'h20, 1'b0);
    @(negedge clk);
    retire = 1'b1; next_pc = 32'h123;
    @(negedge clk);
    retire = 1'b0;
    check("idle_ret_pc", pc, 32'h20);
    check("idle_ret_cnt", retired_cnt, m_cnt);
    imem_rvalid = 1'b1; imem_rdata = 32'h5555;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("idle_ret_issue", {31'b0, instr_valid}, 32'd1);

    // PC wrap: pc_seq of all-ones is zero.
    do_retire(32'hFFFF_FFFF, 1'b0);
    do_fetch(2, 32'h7777);
    check("wrap_pc_seq", pc_seq, 32'h0);
    do_retire(32'h30, 1'b0);

    // rst during WAIT with a late rvalid in the restarted FETCH cycle.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    #1;
    check("late_req", {31'b0, imem_req}, 32'd1);
    check("late_pc", pc, 32'd0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("late_ignored", {31'b0, instr_valid}, 32'd0);
    check("late_instr", instr, 32'd0);

    // 4-cycle latency fetch, then a fetch that times out.
    do_reset();
    do_fetch(4, 32'h4444);
    do_retire(32'd1, 1'b0);
    @(negedge clk);
    for (int i = 1; i < 15; i++) @(negedge clk);
    check("to_not_yet", {31'b0, fault}, 32'd0);
    @(negedge clk);
    check("to_fault", {31'b0, fault}, 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      imem_rvalid = i[0]; retire = 1'b1;
      @(negedge clk);
      if (imem_req || !fault || instr_valid) ok = 1'b0;
    end
    imem_rvalid = 1'b0; retire = 1'b0;
    check("to_hold", {31'b0, ok}, 32'd1);

    // Halt at pc=7, then reset clears it.
    do_reset();
    do_fetch(1, 32'h1);
    do_retire(32'd7, 1'b0);
    do_fetch(3, 32'h2);
    do_retire(32'h99, 1'b1);
    check("halt_pc", pc, 32'd7);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      retire = 1'b1; next_pc = 32'h55; imem_rvalid = i[0];
      @(negedge clk);
      if (imem_req || !halted || pc != 32'd7 || retired_cnt != m_cnt) ok = 1'b0;
    end
    retire = 1'b0; imem_rvalid = 1'b0;
    check("halt_hold", {31'b0, ok}, 32'd1);
    do_reset();
    check("halt_cleared", {31'b0, halted}, 32'd0);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 60; n++) begin
      do_fetch(int'($urandom_range(1, 8)), $urandom);
      for (int k = int'($urandom_range(0, 3)); k > 0; k--) begin
        imem_rvalid = 1'($urandom); imem_rdata = $urandom; halt = 1'($urandom);
        @(negedge clk);
        imem_rvalid = 1'b0; halt = 1'b0;
        check("rnd_hold_valid", {31'b0, instr_valid}, 32'd1);
        check("rnd_hold_instr", instr, m_instr);
      end
      npc = ($urandom_range(0, 1) != 0) ? m_pc + 32'd1 : $urandom;
      do_retire(npc, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
